// File: rtl/hashclk_rst_seq.sv
// hashclk_rst_seq: qualifies PLL lock, then releases core reset and hash enable in order with a gap.
// Ports: clk (board clock), rst_n (async active-low), pll_locked (async lock flag),
//   sw_reset (sync re-sequence request), core_rst_n/hash_en/ready (registered controls),
//   state (WAIT_LOCK=0 STAGE=1 RUN=2 DRAIN=3), lock_loss_cnt (only with HASHCLK_LOCK_LOSS_CNT_EN).
module hashclk_rst_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP = 16,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_reset,
  output logic       core_rst_n,
  output logic       hash_en,
  output logic       ready,
  output logic [1:0] state
`ifdef HASHCLK_LOCK_LOSS_CNT_EN
  ,
  output logic [CNT_W-1:0] lock_loss_cnt
`endif
);
  localparam int MAX_C = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
  localparam int TW = $clog2(MAX_C + 1);
  typedef enum logic [1:0] {WAIT_LOCK = 2'd0, STAGE = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [1:0] sync_q;
  logic core_rst_n_q, hash_en_q;
  logic locked_s, lost;
  assign locked_s = sync_q[1];
  assign lost = !locked_s && state_q != WAIT_LOCK;
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOCK: state_d = (locked_s && cnt_q == TW'(LOCK_STABLE_CYCLES - 1)) ? STAGE : WAIT_LOCK;
      STAGE:     state_d = !locked_s ? WAIT_LOCK : (cnt_q == TW'(STAGE_GAP - 1)) ? RUN : STAGE;
      RUN:       state_d = !locked_s ? WAIT_LOCK : sw_reset ? DRAIN : RUN;
      default:   state_d = (!locked_s || cnt_q == TW'(STAGE_GAP - 1)) ? WAIT_LOCK : DRAIN;
    endcase
    // counter restarts on any state change and on every unlocked cycle while qualifying
    cnt_d = (state_d != state_q || (state_q == WAIT_LOCK && !locked_s)) ? '0 :
            (state_q == RUN) ? cnt_q : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      core_rst_n_q <= 1'b0;
      hash_en_q    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], pll_locked};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_rst_n_q <= state_d != WAIT_LOCK;
      hash_en_q    <= state_d == RUN;
    end
  end
  assign core_rst_n = core_rst_n_q;
  assign hash_en    = hash_en_q;
  assign ready      = hash_en_q;
  assign state      = state_q;
`ifdef HASHCLK_LOCK_LOSS_CNT_EN
  logic [CNT_W-1:0] llc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) llc_q <= '0;
    else if (lost && llc_q != '1) llc_q <= llc_q + 1'b1;
  end
  assign lock_loss_cnt = llc_q;
`else
  logic unused_lost;
  assign unused_lost = lost;
`endif
endmodule

// File: doc/hashclk_rst_seq.md
# hashclk_rst_seq

Reset/enable sequencer directly downstream of the main PLL. Qualifies the PLL lock indication, then releases the hash-core reset and the miner enable in a fixed order with a programmable gap. Runs on the free-running board clock that also feeds the PLL input, so it keeps working while the PLL is unlocked. Hash-clock-domain consumers resynchronise `core_rst_n` and `hash_en` with their own 2-flop synchronisers.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronised-locked cycles required before releasing reset; legal range ≥ 2.
- `STAGE_GAP`, default 16: cycles between `core_rst_n` rise and `hash_en` rise, and between `hash_en` fall and `core_rst_n` fall on drain; legal range ≥ 1.
- `CNT_W`, default 8: width of the lock-loss counter.

Ports:
- `clk` in 1: board clock, the PLL input clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock flag, asynchronous to `clk`.
- `sw_reset` in 1: synchronous request, one cycle or longer, for an orderly re-sequence.
- `core_rst_n` out 1: active-low reset to the hash cores.
- `hash_en` out 1: miner/nonce-generator enable.
- `ready` out 1: high in RUN only.
- `state` out 2: current state, encoded WAIT_LOCK=0, STAGE=1, RUN=2, DRAIN=3.
- `lock_loss_cnt` out CNT_W: present only with `HASHCLK_LOCK_LOSS_CNT_EN`.

## Operation
- `pll_locked` passes through a 2-flop synchroniser. Its output is `locked_s`.
- One internal counter, width $clog2(max(LOCK_STABLE_CYCLES, STAGE_GAP)+1), is cleared on every state change.
- All outputs are registered together with the state (Moore):
  - `core_rst_n` = 1 in STAGE, RUN and DRAIN.
  - `hash_en` = `ready` = 1 in RUN only.
- WAIT_LOCK:
  - `locked_s`=1: increment the counter.
  - `locked_s`=0: clear the counter.
  - After LOCK_STABLE_CYCLES consecutive high cycles, go to STAGE.
- STAGE: count STAGE_GAP cycles, then go to RUN.
- RUN: `sw_reset`=1 goes to DRAIN.
- DRAIN: count STAGE_GAP cycles, then go to WAIT_LOCK. The full lock qualification repeats.
- Lock loss: `locked_s`=0 in STAGE, RUN or DRAIN goes directly to WAIT_LOCK. Lock loss has priority over `sw_reset` and over the gap count.
- `sw_reset` is ignored in WAIT_LOCK, STAGE and DRAIN. It is level-sampled, so holding it high in RUN has the same effect as a single pulse.
- Reset (`rst_n`=0) at any time, including mid-sequence:
  - state WAIT_LOCK, counter 0, synchroniser flops 0.
  - `core_rst_n`=0, `hash_en`=0, `ready`=0, `state`=0, `lock_loss_cnt`=0.

## Timing
Let edge 0 be the first `clk` rising edge that samples `pll_locked`=1.
- `locked_s`=1 after edge 1.
- `core_rst_n`=1 after edge LOCK_STABLE_CYCLES+1.
- `hash_en`=`ready`=1 after edge LOCK_STABLE_CYCLES+1+STAGE_GAP.
- A `pll_locked` glitch low lasting one or more sampled cycles before qualification completes restarts the count from zero.

Lock loss, with edge 0 sampling `pll_locked`=0:
- `locked_s`=0 after edge 1.
- All outputs low and state WAIT_LOCK after edge 2.
- `core_rst_n` and `hash_en` fall in the same cycle. There is no drain ordering on lock loss.

`sw_reset` sampled high in RUN at edge 0:
- `hash_en`=`ready`=0 after edge 0.
- `core_rst_n`=0 after edge STAGE_GAP.

Ordering invariant: `hash_en`=1 implies `core_rst_n`=1 in every cycle.

## Configuration
- `HASHCLK_LOCK_LOSS_CNT_EN` defined:
  - `lock_loss_cnt` port exists.
  - It increments by 1 on each transition into WAIT_LOCK caused by `locked_s`=0 from STAGE, RUN or DRAIN.
  - It saturates at 2^CNT_W−1.
  - Reset value is 0.
- `HASHCLK_LOCK_LOSS_CNT_EN` undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
All scenarios use LOCK_STABLE_CYCLES=8, STAGE_GAP=4, CNT_W=2.
- Clean lock: `pll_locked` rises sampled at edge 0 → `core_rst_n` 1 after edge 9; `hash_en` and `ready` 1 after edge 13; `state` shows 0, then 1, then 2.
- Glitch: `pll_locked` high 5 cycles, low 1 sampled cycle, then high → `core_rst_n` rises 9 edges after the re-rise.
- Lock loss in RUN: `pll_locked` drops sampled at edge 0 → all outputs 0 and `state`=0 after edge 2; `lock_loss_cnt` goes 0→1.
  - Repeat four times → `lock_loss_cnt` saturates at 3.
- Drain: 1-cycle `sw_reset` in RUN at edge 0 with lock held → `hash_en` 0 after edge 0; `core_rst_n` 0 after edge 4; `core_rst_n` rises again after edge 12.
- Priority and reset:
  - Lock loss during DRAIN → WAIT_LOCK 2 edges after sampling.
  - `sw_reset` in STAGE → ignored, RUN reached on schedule.
  - `rst_n` pulse in RUN → all outputs 0 immediately, asynchronously.
  - Assertion across all runs: never `hash_en`=1 while `core_rst_n`=0.
